// File: rtl/lowpass_decimator.sv
// Output stage of the lowpass FIR: keeps one valid sample in every DECIM,
// rounds it half-up from DW_IN to DW_OUT bits with saturation, and queues
// it in a show-ahead FIFO that drains over a valid/ready handshake.
// Kept samples arriving while the FIFO is full are dropped and counted.
module lowpass_decimator #(
  parameter int DW_IN  = 18,
  parameter int DW_OUT = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DW_IN-1:0]         din,
  input  logic                     din_valid,
  input  logic                     sync,
  output logic [DW_OUT-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int SH = DW_IN - DW_OUT;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
  // Phase after a sync that coincides with a kept sample.
  localparam logic [PW-1:0] PH_SYNC  = (DECIM == 1) ? {PW{1'b0}} : PW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  localparam logic signed [DW_IN:0] RND_C = {{DW_IN{1'b0}}, 1'b1} << (SH - 1);
  localparam logic signed [DW_IN:0] MAX_C = {{(SH + 2){1'b0}}, {(DW_OUT - 1){1'b1}}};
  localparam logic signed [DW_IN:0] MIN_C = ~MAX_C;

  // Round half-up by SH bits in DW_IN+1 signed bits, then clamp to DW_OUT.
  function automatic logic [DW_OUT-1:0] round_sat(input logic [DW_IN-1:0] x);
    logic signed [DW_IN:0] t;
    logic signed [DW_IN:0] r;
    logic [DW_OUT-1:0]     y;
    t = $signed({x[DW_IN-1], x}) + RND_C;
    r = t >>> SH;
    if (r > MAX_C) begin
      y = MAX_C[DW_OUT-1:0];
    end else if (r < MIN_C) begin
      y = MIN_C[DW_OUT-1:0];
    end else begin
      y = r[DW_OUT-1:0];
    end
    return y;
  endfunction

  logic [PW-1:0]     phase_q, phase_d;
  logic              rv_q, rv_d;
  logic [DW_OUT-1:0] stage_q, stage_d;
  logic [DW_OUT-1:0] mem_q [DEPTH];
  logic [DW_OUT-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_count_q, drop_count_d;

  logic keep_s, pop_s, push_s, drop_s, full_s, empty_s;

  // Decimation phase, keep decision and round/saturate stage register.
  always_comb begin
    phase_d = phase_q;
    keep_s  = din_valid & ((phase_q == {PW{1'b0}}) | sync);
    rv_d    = keep_s;
    stage_d = stage_q;
    if (keep_s) begin
      stage_d = round_sat(din);
    end else begin
      stage_d = stage_q;
    end
    if (din_valid) begin
      if (sync) begin
        phase_d = PH_SYNC;
      end else if (phase_q == PH_LAST) begin
        phase_d = {PW{1'b0}};
      end else begin
        phase_d = phase_q + PW'(1'b1);
      end
    end else if (sync) begin
      phase_d = {PW{1'b0}};
    end else begin
      phase_d = phase_q;
    end
  end

  // FIFO push/pop, occupancy and drop accounting.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    empty_s      = (count_q == {CW{1'b0}});
    full_s       = (count_q == CNT_FULL);
    pop_s        = ~empty_s & dout_ready;
    push_s       = rv_q & (~full_s | pop_s);
    drop_s       = rv_q & full_s & ~pop_s;
    if (push_s) begin
      mem_d[wr_ptr_q] = stage_q;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  // State registers with synchronous reset; reset discards any in-flight sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q      <= {PW{1'b0}};
      rv_q         <= 1'b0;
      stage_q      <= {DW_OUT{1'b0}};
      mem_q        <= '{default: '0};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      phase_q      <= phase_d;
      rv_q         <= rv_d;
      stage_q      <= stage_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = (count_q != {CW{1'b0}});
  assign level      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lowpass_decimator.sv
// Self-checking bench: two instances (DECIM=4 and DECIM=1) share stimulus and
// are compared every cycle against a queue-based reference model, plus
// directed scenarios with hand-computed expectations.
module tb_lowpass_decimator;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] din;
  logic        din_valid;
  logic        sync;
  logic        dout_ready;

  logic [15:0] dout_a, dout_b;
  logic        dv_a, dv_b;
  logic [3:0]  lvl_a, lvl_b;
  logic        ovf_a, ovf_b;
  logic [7:0]  dc_a, dc_b;

  always #5 clock = ~clock;

  lowpass_decimator #(.DW_IN(18), .DW_OUT(16), .DECIM(4), .DEPTH(8)) dut_d4 (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .dout(dout_a), .dout_valid(dv_a), .dout_ready(dout_ready),
    .level(lvl_a), .overflow(ovf_a), .drop_count(dc_a)
  );

  lowpass_decimator #(.DW_IN(18), .DW_OUT(16), .DECIM(1), .DEPTH(8)) dut_d1 (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .dout(dout_b), .dout_valid(dv_b), .dout_ready(dout_ready),
    .level(lvl_b), .overflow(ovf_b), .drop_count(dc_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 = DECIM 4, index 1 = DECIM 1.
  int m_ph[2];
  int m_rv[2];
  int m_sv[2];
  int m_ovf[2];
  int m_dc[2];
  int fq0[$];
  int fq1[$];
  int obs[$];

  task automatic check_eq(input string tag, input logic signed [31:0] o, input logic signed [31:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic int q_front(input int i);
    return (i == 0) ? fq0[0] : fq1[0];
  endfunction

  task automatic q_push(input int i, input int v);
    if (i == 0) fq0.push_back(v);
    else fq1.push_back(v);
  endtask

  task automatic q_pop(input int i);
    if (i == 0) void'(fq0.pop_front());
    else void'(fq1.pop_front());
  endtask

  // Round half-up of x/4 using floor division, then clamp to 16-bit signed.
  function automatic int ref_round(input int x);
    int t;
    int r;
    t = x + 2;
    r = (t >= 0) ? t / 4 : -((3 - t) / 4);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset(input int i);
    m_ph[i] = 0; m_rv[i] = 0; m_sv[i] = 0; m_ovf[i] = 0; m_dc[i] = 0;
    if (i == 0) fq0.delete();
    else fq1.delete();
  endtask

  task automatic model_step(input int i, input int d);
    int pop;
    int drop;
    int keep;
    if (reset) begin
      model_reset(i);
    end else begin
      pop  = (q_size(i) > 0) && dout_ready;
      drop = m_rv[i] && (q_size(i) == 8) && !pop;
      if (pop) q_pop(i);
      if (m_rv[i] && !drop) q_push(i, m_sv[i]);
      if (drop) begin
        m_ovf[i] = 1;
        if (m_dc[i] < 255) m_dc[i]++;
      end
      keep = din_valid && ((m_ph[i] == 0) || sync);
      m_rv[i] = keep;
      if (keep) m_sv[i] = ref_round(int'($signed(din)));
      if (din_valid) m_ph[i] = sync ? ((d == 1) ? 0 : 1) : ((m_ph[i] + 1) % d);
      else if (sync) m_ph[i] = 0;
    end
  endtask

  task automatic check_outputs(input int i);
    string p;
    logic [15:0] d;
    logic v, o;
    logic [3:0] l;
    logic [7:0] c;
    p = (i == 0) ? "d4" : "d1";
    d = (i == 0) ? dout_a : dout_b;
    v = (i == 0) ? dv_a : dv_b;
    l = (i == 0) ? lvl_a : lvl_b;
    o = (i == 0) ? ovf_a : ovf_b;
    c = (i == 0) ? dc_a : dc_b;
    check_eq({p, ".level"}, l, q_size(i));
    check_eq({p, ".dout_valid"}, v, (q_size(i) != 0));
    check_eq({p, ".overflow"}, o, m_ovf[i]);
    check_eq({p, ".drop_count"}, c, m_dc[i]);
    if (q_size(i) > 0) check_eq({p, ".dout"}, $signed(d), q_front(i));
  endtask

  // One clock: compare outputs with the model, record d4 pops, advance.
  task automatic step();
    check_outputs(0);
    check_outputs(1);
    if (dv_a && dout_ready && !reset) obs.push_back(int'($signed(dout_a)));
    model_step(0, 4);
    model_step(1, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; din_valid = 1'b0; sync = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [17:0] rs_in [8];
  int          rs_exp [8];

  initial begin
    reset = 1'b1; din = 18'd0; din_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset(0);
    model_reset(1);
    reset = 1'b0;

    // Reset state
    check_eq("rst.dout", dout_a, 0);
    check_eq("rst.dout_valid", dv_a, 0);
    check_eq("rst.level", lvl_a, 0);
    check_eq("rst.overflow", ovf_a, 0);
    check_eq("rst.drop_count", dc_a, 0);
    check_eq("rst.d1_level", lvl_b, 0);

    // Decimation: strobe every 3rd cycle, 12 samples, DECIM 4 keeps 0,4,8
    do_reset();
    dout_ready = 1'b1;
    obs.delete();
    for (int k = 0; k < 12; k++) begin
      din = 18'(4 * k); din_valid = 1'b1; step();
      din_valid = 1'b0; step(); step();
    end
    repeat (4) step();
    check_eq("decim.count", obs.size(), 3);
    for (int j = 0; j < 3 && j < obs.size(); j++) check_eq("decim.value", obs[j], 4 * j);

    // Rounding and saturation, 2 cycles after input
    rs_in = '{18'd6, 18'd5, 18'h3FFFA, 18'h3FFF9, 18'h3FFFB, 18'h1FFFF, 18'h20000, 18'h1FFFD};
    rs_exp = '{2, 1, -1, -2, -1, 32767, -32768, 32767};
    do_reset();
    dout_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      din = rs_in[j]; din_valid = 1'b1; sync = 1'b1; step();
      din_valid = 1'b0; sync = 1'b0; step();
      check_eq("round.d1_valid", dv_b, 1);
      check_eq("round.d1_dout", $signed(dout_b), rs_exp[j]);
      check_eq("round.d4_dout", $signed(dout_a), rs_exp[j]);
      step(); step();
    end

    // Overflow: 48 strobes with consumer stalled, then drain
    do_reset();
    dout_ready = 1'b0;
    for (int k = 0; k < 48; k++) begin
      din = 18'(4 * k); din_valid = 1'b1; step();
    end
    din_valid = 1'b0;
    step(); step();
    check_eq("ovf.level", lvl_a, 8);
    check_eq("ovf.overflow", ovf_a, 1);
    check_eq("ovf.drop_count", dc_a, 4);
    obs.delete();
    dout_ready = 1'b1;
    repeat (10) step();
    check_eq("ovf.drained", obs.size(), 8);
    for (int j = 0; j < 8 && j < obs.size(); j++) check_eq("ovf.order", obs[j], 4 * j);
    check_eq("ovf.level_empty", lvl_a, 0);
    check_eq("ovf.sticky", ovf_a, 1);

    // Full with simultaneous push and pop
    do_reset();
    dout_ready = 1'b0;
    obs.delete();
    for (int k = 0; k <= 32; k++) begin
      din = 18'(4 * k); din_valid = 1'b1; step();
    end
    din_valid = 1'b0; dout_ready = 1'b1; step();
    dout_ready = 1'b0; step();
    check_eq("pp.level", lvl_a, 8);
    check_eq("pp.drop_count", dc_a, 0);
    check_eq("pp.overflow", ovf_a, 0);
    dout_ready = 1'b1;
    repeat (10) step();
    check_eq("pp.total", obs.size(), 9);
    if (obs.size() == 9) check_eq("pp.last", obs[8], 32);

    // sync with din_valid on phase 2
    do_reset();
    dout_ready = 1'b1;
    obs.delete();
    for (int k = 0; k < 7; k++) begin
      din = 18'(4 * k); din_valid = 1'b1; sync = (k == 2); step();
    end
    din_valid = 1'b0; sync = 1'b0;
    repeat (5) step();
    check_eq("sync.count", obs.size(), 3);
    if (obs.size() == 3) begin
      check_eq("sync.v0", obs[0], 0);
      check_eq("sync.v1", obs[1], 2);
      check_eq("sync.v2", obs[2], 6);
    end

    // Reset mid-stream with 5 queued entries and the stage register loaded
    do_reset();
    dout_ready = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      din = 18'(4 * k); din_valid = 1'b1; step();
    end
    check_eq("rstmid.level_before", lvl_a, 5);
    reset = 1'b1; din = 18'd400; din_valid = 1'b1; step();
    reset = 1'b0; din_valid = 1'b0;
    check_eq("rstmid.level", lvl_a, 0);
    check_eq("rstmid.dout_valid", dv_a, 0);
    obs.delete();
    dout_ready = 1'b1;
    din = 18'd28; din_valid = 1'b1; step();
    din_valid = 1'b0;
    repeat (4) step();
    check_eq("rstmid.first_count", obs.size(), 1);
    if (obs.size() == 1) check_eq("rstmid.first", obs[0], 7);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 399) == 0);
      din_valid  = ($urandom_range(0, 3) != 0);
      sync       = ($urandom_range(0, 19) == 0);
      dout_ready = (n % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       din = 18'h1FFFF - 18'($urandom_range(0, 7));
        1:       din = 18'h20000 + 18'($urandom_range(0, 7));
        default: din = 18'($urandom);
      endcase
      step();
    end
    reset = 1'b0; din_valid = 1'b0; sync = 1'b0; dout_ready = 1'b1;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
